// File: rtl/ltl_symbol_encoder.sv
// ltl_symbol_encoder
//   Transmit side of the LTL runtime-monitor symbol stream. Samples
//   atomic-proposition bits, packs each sample into an 8-bit symbol
//   {zeros, props}, buffers symbols in a FIFO and drives the
//   symbols/run/reset inputs of one automata monitor cluster. Also
//   produces the automata reset pulse that starts each new trace.
//
//   Optional feature macro: LTL_SYM_DEDUP_EN
//     defined   -> a sample is pushed only if it differs from the last
//                  pushed value of the current trace
//     undefined -> every accepted valid sample is pushed
//
// Ports
//   clk            clock, all flops on posedge
//   reset          asynchronous active-high reset
//   trace_start    pulse: start (or restart) a trace
//   trace_stop     pulse: end the trace once the FIFO drains
//   prop_valid     props sample valid this cycle
//   props          atomic-proposition values [NPROP-1:0]
//   sym_ready      consumer can take a symbol this cycle
//   automata_reset automata reset input
//   run            symbol transfer strobe
//   symbols        FIFO head symbol
//   busy           state is not IDLE
//   overflow       sticky: a sample was dropped on a full FIFO
//   sym_count      symbols issued since last trace_start, saturating
module ltl_symbol_encoder #(
   parameter int unsigned NPROP      = 4,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned RST_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             trace_start,
   input  logic             trace_stop,
   input  logic             prop_valid,
   input  logic [NPROP-1:0] props,
   input  logic             sym_ready,
   output logic             automata_reset,
   output logic             run,
   output logic [7:0]       symbols,
   output logic             busy,
   output logic             overflow,
   output logic [31:0]      sym_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(RST_CYCLES + 1);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_STREAM, ST_DRAIN} state_t;

   state_t        r_state;
   logic [CW-1:0] r_arm_cnt;
   logic          r_automata_reset;
   logic          r_busy;
   logic          r_overflow;
   logic [31:0]   r_sym_count;
   logic [7:0]    r_mem [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;

   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_offer;
   logic          w_push;
   logic          w_dup;
   logic [7:0]    w_sym_in;

   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop    = ((r_state == ST_STREAM) || (r_state == ST_DRAIN)) &&
                     !w_empty && sym_ready;
   // A sample is a push candidate only in ARM/STREAM and never in a
   // restart cycle; duplicates are filtered before the full check so
   // they cannot raise overflow.
   assign w_offer  = prop_valid && ((r_state == ST_ARM) || (r_state == ST_STREAM)) &&
                     !trace_start && !w_dup;
   assign w_push   = w_offer && (!w_full || w_pop);
   assign w_sym_in = 8'(props);

`ifdef LTL_SYM_DEDUP_EN
   logic [NPROP-1:0] r_last;
   logic             r_last_vld;

   assign w_dup = r_last_vld && (props == r_last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last     <= '0;
         r_last_vld <= 1'b0;
      end else if (trace_start) begin
         r_last_vld <= 1'b0;
      end else if (w_push) begin
         r_last     <= props;
         r_last_vld <= 1'b1;
      end
   end
`else
   assign w_dup = 1'b0;
`endif

   assign run            = w_pop;
   assign symbols        = r_mem[r_rd_ptr[AW-1:0]];
   assign automata_reset = r_automata_reset;
   assign busy           = r_busy;
   assign overflow       = r_overflow;
   assign sym_count      = r_sym_count;

   // Control FSM; trace_start from any state (re)enters ARM with the
   // hold counter reloaded and wins over a simultaneous trace_stop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state          <= ST_IDLE;
         r_arm_cnt        <= '0;
         r_automata_reset <= 1'b1;
         r_busy           <= 1'b0;
      end else if (trace_start) begin
         r_state          <= ST_ARM;
         r_arm_cnt        <= CW'(RST_CYCLES - 1);
         r_automata_reset <= 1'b1;
         r_busy           <= 1'b1;
      end else begin
         case (r_state)
            ST_ARM: begin
               if (r_arm_cnt == '0) begin
                  r_state          <= ST_STREAM;
                  r_automata_reset <= 1'b0;
               end else begin
                  r_arm_cnt <= r_arm_cnt - CW'(1);
               end
            end
            ST_STREAM: begin
               if (trace_stop) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (w_empty) begin
                  r_state          <= ST_IDLE;
                  r_automata_reset <= 1'b1;
                  r_busy           <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // FIFO storage, pointers, overflow flag and issue counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_overflow  <= 1'b0;
         r_sym_count <= '0;
      end else if (trace_start) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_overflow  <= 1'b0;
         r_sym_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_sym_in;
            r_wr_ptr                <= r_wr_ptr + PTR_ONE;
         end
         if (w_offer && w_full && !w_pop) r_overflow <= 1'b1;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (r_sym_count != '1) r_sym_count <= r_sym_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_ltl_symbol_encoder.sv
// tb_ltl_symbol_encoder
//   Scoreboard bench for ltl_symbol_encoder. A trace-level reference
//   model (phase, queue of pending symbols, sticky flag, counter)
//   predicts outputs; expected symbols go into a queue that a negedge
//   monitor pops whenever the DUT strobes run.
//   Honours LTL_SYM_DEDUP_EN the same way the design does.
module tb_ltl_symbol_encoder;

   localparam int unsigned NPROP      = 4;
   localparam int unsigned DEPTH      = 8;
   localparam int unsigned RST_CYCLES = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             trace_start;
   logic             trace_stop;
   logic             prop_valid;
   logic [NPROP-1:0] props;
   logic             sym_ready;
   logic             automata_reset;
   logic             run;
   logic [7:0]       symbols;
   logic             busy;
   logic             overflow;
   logic [31:0]      sym_count;

   always #5 clk = ~clk;

   ltl_symbol_encoder #(
      .NPROP(NPROP),
      .DEPTH(DEPTH),
      .RST_CYCLES(RST_CYCLES)
   ) dut (
      .clk(clk),
      .reset(reset),
      .trace_start(trace_start),
      .trace_stop(trace_stop),
      .prop_valid(prop_valid),
      .props(props),
      .sym_ready(sym_ready),
      .automata_reset(automata_reset),
      .run(run),
      .symbols(symbols),
      .busy(busy),
      .overflow(overflow),
      .sym_count(sym_count)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_ARM, M_STREAM, M_DRAIN} mphase_t;

   mphase_t          m_phase;
   int               m_arm_left;
   logic [7:0]       m_fifo[$];
   logic [7:0]       exp_q[$];
   logic             m_ovf;
   logic [31:0]      m_cnt;
   logic             m_last_vld;
   logic [NPROP-1:0] m_last;

   logic             e_run, e_ar, e_busy, e_ovf;
   logic [31:0]      e_cnt;
   logic             mon_en = 1'b0;

   function automatic logic [7:0] sym_of(input logic [NPROP-1:0] p);
      logic [7:0] s;
      s = '0;
      s[NPROP-1:0] = p;
      return s;
   endfunction

   task automatic model_reset();
      m_phase    = M_IDLE;
      m_arm_left = 0;
      m_fifo.delete();
      exp_q.delete();
      m_ovf      = 1'b0;
      m_cnt      = '0;
      m_last_vld = 1'b0;
      m_last     = '0;
   endtask

   // One clock cycle: drive inputs, publish expected outputs for the
   // monitor, then advance the model across the coming edge.
   task automatic cycle(input logic ts, input logic tp, input logic pv,
                        input logic [NPROP-1:0] pr, input logic sr);
      logic run_m, dup, offer;
      int   occ;
      trace_start = ts;
      trace_stop  = tp;
      prop_valid  = pv;
      props       = pr;
      sym_ready   = sr;
      run_m  = ((m_phase == M_STREAM) || (m_phase == M_DRAIN)) && (m_fifo.size() > 0) && sr;
      e_run  = run_m;
      e_ar   = (m_phase == M_IDLE) || (m_phase == M_ARM);
      e_busy = (m_phase != M_IDLE);
      e_ovf  = m_ovf;
      e_cnt  = m_cnt;
      @(negedge clk);
      #1;
      occ = m_fifo.size();
      if (ts) begin
         m_fifo.delete();
         exp_q.delete();
         m_ovf      = 1'b0;
         m_cnt      = '0;
         m_phase    = M_ARM;
         m_arm_left = RST_CYCLES;
         m_last_vld = 1'b0;
      end else begin
         if (run_m) begin
            void'(m_fifo.pop_front());
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
         end
`ifdef LTL_SYM_DEDUP_EN
         dup = m_last_vld && (pr == m_last);
`else
         dup = 1'b0;
`endif
         offer = pv && ((m_phase == M_ARM) || (m_phase == M_STREAM)) && !dup;
         if (offer) begin
            if ((occ < int'(DEPTH)) || run_m) begin
               m_fifo.push_back(sym_of(pr));
               exp_q.push_back(sym_of(pr));
               m_last     = pr;
               m_last_vld = 1'b1;
            end else begin
               m_ovf = 1'b1;
            end
         end
         case (m_phase)
            M_ARM: begin
               m_arm_left--;
               if (m_arm_left == 0) m_phase = M_STREAM;
            end
            M_STREAM: if (tp) m_phase = M_DRAIN;
            M_DRAIN:  if (occ == 0) m_phase = M_IDLE;
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic sr);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, sr);
   endtask

   task automatic check_reset_values();
      check("rst_run",            32'(run),            32'd0);
      check("rst_automata_reset", 32'(automata_reset), 32'd1);
      check("rst_symbols",        32'(symbols),        32'd0);
      check("rst_busy",           32'(busy),           32'd0);
      check("rst_overflow",       32'(overflow),       32'd0);
      check("rst_sym_count",      sym_count,           32'd0);
   endtask

   // Asynchronous reset landing mid-cycle, away from the clock edge.
   task automatic async_reset();
      mon_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_reset_values();
      trace_start = 1'b0;
      trace_stop  = 1'b0;
      prop_valid  = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         check("run",            32'(run),            32'(e_run));
         check("automata_reset", 32'(automata_reset), 32'(e_ar));
         check("busy",           32'(busy),           32'(e_busy));
         check("overflow",       32'(overflow),       32'(e_ovf));
         check("sym_count",      sym_count,           e_cnt);
         if (run) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL symbols: run with no expected symbol, got 0x%0h at %0t", symbols, $time);
            end else begin
               check("symbols", 32'(symbols), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset       = 1'b1;
      trace_start = 1'b0;
      trace_stop  = 1'b0;
      prop_valid  = 1'b0;
      props       = '0;
      sym_ready   = 1'b0;
      model_reset();
      #2;
      check_reset_values();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // trace start, ARM hold, then three back-to-back symbols
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
      idle(2, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 4'h3, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 4'h8, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 4'hF, 1'b1);
      idle(3, 1'b1);

      // fill past capacity with the consumer stalled, then drain
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, NPROP'(i), 1'b0);
      idle(10, 1'b1);

      // stop with three entries queued; samples in DRAIN are ignored
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, NPROP'(i + 4), 1'b0);
      cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, NPROP'($urandom_range(0, 15)), 1'b1);
      idle(2, 1'b1);

      // restart mid-STREAM with five queued and a sample in the restart cycle
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
      idle(2, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, NPROP'(i + 9), 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 4'h7, 1'b0);
      idle(4, 1'b1);

      // repeated values
      cycle(1'b0, 1'b0, 1'b1, 4'h2, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 4'h2, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 4'h2, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 4'h5, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 4'h5, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 4'h2, 1'b1);
      idle(4, 1'b1);

      // asynchronous reset with symbols pending and the consumer ready
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, NPROP'(i + 9), 1'b0);
      sym_ready = 1'b1;
      async_reset();
      idle(2, 1'b1);

      // randomized traffic
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 3000; i++) begin
         logic             ts, tp, pv, sr;
         logic [NPROP-1:0] pr;
         ts = ($urandom_range(0, 59) == 0);
         tp = ($urandom_range(0, 24) == 0);
         pv = ($urandom_range(0, 9) < 7);
         sr = ($urandom_range(0, 9) < 6);
         pr = ($urandom_range(0, 1) == 0) ? NPROP'($urandom_range(0, 3))
                                          : NPROP'($urandom_range(0, 15));
         if (m_phase == M_IDLE && $urandom_range(0, 3) == 0) ts = 1'b1;
         cycle(ts, tp, pv, pr, sr);
      end
      idle(20, 1'b1);

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ltl_symbol_encoder.md
Name: ltl_symbol_encoder

Overview:
- Transmit side of the LTL runtime-monitor symbol stream.
- Samples atomic-proposition bits from the core and packs each sample into an 8-bit symbol.
- Buffers symbols in a small FIFO and drives the symbols/run/reset inputs of one Automata_* monitor cluster.
- Also produces the reset pulse that starts a new trace, so the automata's start_of_data fires exactly once per trace.

Parameters:
NPROP, 4, number of proposition bits; 1..8. Symbol = {(8-NPROP) zeros, props}.
DEPTH, 8, FIFO entries; power of two, at least 2.
RST_CYCLES, 2, cycles automata_reset is held high at trace start; at least 1.

Ports:
clk  input  1  clock; all flops on posedge.
reset  input  1  asynchronous, active-high reset of this block.
trace_start  input  1  one-cycle pulse: begin a new trace (also restarts a running one).
trace_stop  input  1  one-cycle pulse: end the trace after the FIFO drains.
prop_valid  input  1  props sample valid this cycle.
props  input  NPROP  atomic-proposition values.
sym_ready  input  1  consumer can take a symbol this cycle; tie to 1 for automata.
automata_reset  output  1  drives the automata reset input.
run  output  1  symbol transfer strobe; drives the automata run input.
symbols  output  8  current symbol (FIFO head).
busy  output  1  state is not IDLE.
overflow  output  1  sticky: a sample was dropped because the FIFO was full.
sym_count  output  32  symbols issued since the last trace_start; saturates at 2^32-1.

Behaviour:
- Reset values: automata_reset=1, run=0, symbols=0, busy=0, overflow=0, sym_count=0, FIFO empty, state IDLE.
- FSM states: IDLE, ARM, STREAM, DRAIN.
  - IDLE: automata_reset=1. On trace_start go to ARM.
  - ARM: automata_reset=1 for exactly RST_CYCLES cycles, counted from ARM entry, then go to STREAM. Samples are accepted into the FIFO during ARM but not issued.
  - STREAM: automata_reset=0. Accept samples and issue symbols. On trace_stop go to DRAIN.
  - DRAIN: ignore new samples, keep issuing. When the FIFO is empty and no pop is in progress, go to IDLE. automata_reset rises the cycle IDLE is entered.
- trace_start in ARM, STREAM or DRAIN restarts the trace:
  - FIFO flushed, overflow cleared, sym_count cleared, ARM re-entered with its counter reloaded.
  - A sample presented in the same cycle is discarded.
  - trace_start takes priority over a simultaneous trace_stop.
- trace_stop in IDLE or ARM is ignored.
- Push: prop_valid while in ARM or STREAM and not restarting.
  - If the FIFO is full and no pop occurs this cycle, the sample is dropped and overflow is set.
  - If full with a simultaneous pop, the push succeeds.
- Pop/issue: run = (STREAM or DRAIN) & !empty & sym_ready. symbols = FIFO head, combinational from the storage array. Head advances on the run cycle.
- symbols holds its value when run=0; it shows the stale head if the FIFO is empty.
- Latency: a sample pushed at cycle N appears with run=1 at cycle N+1 at the earliest (empty FIFO, STREAM, sym_ready=1).
- Pointers: log2(DEPTH)+1 bits with wrap bit. full = MSBs differ and LSBs equal. empty = pointers equal.
- sym_count increments on each run and saturates.
- Asynchronous reset asserted mid-trace returns everything immediately to reset values, with no partial symbol issued.

Optional Feature:
LTL_SYM_DEDUP_EN:
- Defined: a sample is pushed only if its props differ from the last pushed value. The last-value register is invalidated on trace_start and reset, so the first sample of each trace is always pushed. Duplicates never set overflow.
- Undefined: every valid sample is pushed.

Test Plan:
- Reset, then trace_start with RST_CYCLES=2 -> automata_reset high for exactly 2 cycles after ARM entry, then 0. busy=1. sym_count=0.
- STREAM, sym_ready=1, props 0x3, 0x8, 0xF on consecutive cycles -> run=1 on the next three cycles with symbols 0x03, 0x08, 0x0F. sym_count=3.
- sym_ready=0, 10 valid samples 0..9, DEPTH=8 -> samples 8 and 9 dropped, overflow=1. Raising sym_ready then issues symbols 0..7 in order.
- trace_stop with 3 entries queued -> 3 more run pulses, then IDLE with automata_reset=1 and busy=0. Samples offered during DRAIN are never issued.
- trace_start mid-STREAM with 5 entries queued -> FIFO flushed, no run for the duration of ARM, sym_count and overflow cleared.
- With LTL_SYM_DEDUP_EN defined, props 0x2,0x2,0x2,0x5,0x5,0x2 -> issued symbols 0x02, 0x05, 0x02. Without the macro all six are issued.
